mem_responder: RTL and testbench

//  Memory-side responder for the Control unit's memory handshake. Services the

---
 rtl/mem_responder_pkg.sv | 39 +++
 rtl/mem_ram_sp.sv | 36 +++
 rtl/mem_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_responder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Definitions shared by the memory responder and the Control unit side:
//   FSM state encodings, the memory-mapped I/O word addresses, the latched
//   request record and a RAM range-check helper.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    MR_IDLE   = 2'd0,
    MR_ACCESS = 2'd1,
    MR_DONE   = 2'd2
  } mr_state_e;

  // Word addresses decoded as I/O when the I/O option is built in.
  localparam logic [31:0] MR_IO_IN_ADDR  = 32'hFFFF_FFF0;
  localparam logic [31:0] MR_IO_OUT_ADDR = 32'hFFFF_FFF1;

  // Width of the wait-state counter (WAIT_STATES is limited to 0..15).
  localparam int unsigned MR_CNT_W = 4;

  // Request captured when IDLE accepts a read/write.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mr_req_t;

  // True when a word address selects a location of the on-chip RAM:
  // no bits set above the index field and below the configured depth.
  function automatic logic mr_in_ram(input logic [31:0] addr,
                                     input int unsigned addr_w,
                                     input int unsigned depth);
    return ((addr >> addr_w) == 32'd0) && (addr < depth);
  endfunction

endpackage : mem_responder_pkg

// File: rtl/mem_ram_sp.sv
// -----------------------------------------------------------------------------
// mem_ram_sp
//   Single-port synchronous RAM, 32-bit words, one-cycle read latency.
//   A read and a write to the same word in the same cycle return the old
//   contents (read-first).
//
// Ports
//   iClk   in   1        clock, rising edge
//   iWe    in   1        write enable
//   iAddr  in   ADDR_W   word index
//   iD     in   32       write data
//   oQ     out  32       registered read data for the previous cycle's iAddr
// -----------------------------------------------------------------------------
module mem_ram_sp #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              iClk,
  input  logic              iWe,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iD,
  output logic [31:0]       oQ
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; clearing it would need a write port
  // per word and is not required - contents simply persist across nRst.
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem_q[iAddr] <= iD;
    end
    oQ <= mem_q[iAddr];
  end

endmodule : mem_ram_sp

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the Control unit's fetch and load/store
//   handshake. Accepts a held read/write request, waits WAIT_STATES extra
//   cycles, performs the access on an on-chip word RAM and pulses oRdy for
//   one cycle with oData/oErr valid. While idle, oRdy follows
//   ~(iRead|iWrite) so steps that do not touch memory never stall.
//
// Parameters
//   DEPTH        RAM size in 32-bit words
//   ADDR_W       RAM index width, clog2(DEPTH)
//   WAIT_STATES  extra ACCESS cycles before the response (0..15)
//
// Ports
//   iClk      in   1   clock, rising edge
//   nRst      in   1   synchronous active-low reset
//   iAddr     in   32  word address (MA register)
//   iData     in   32  write data (MD register)
//   iRead     in   1   read request, held until oRdy
//   iWrite    in   1   write request, held until oRdy
//   oData     out  32  read data, valid with oRdy after a read; holds otherwise
//   oRdy      out  1   step-advance permission to Control
//   oErr      out  1   out-of-range access flag, coincident with oRdy
//   iInPort   in   32  input port, read at MR_IO_IN_ADDR   (MEMRESP_IO_EN)
//   oOutPort  out  32  output port, written at MR_IO_OUT_ADDR (MEMRESP_IO_EN)
//
// Configuration
//   MEMRESP_IO_EN  when defined, adds the two I/O ports and decodes
//                  MR_IO_IN_ADDR / MR_IO_OUT_ADDR as I/O; when undefined
//                  those addresses are ordinary out-of-range accesses.
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  input  logic        iRead,
  input  logic        iWrite,
`ifdef MEMRESP_IO_EN
  input  logic [31:0] iInPort,
  output logic [31:0] oOutPort,
`endif
  output logic [31:0] oData,
  output logic        oRdy,
  output logic        oErr
);

  localparam logic [MR_CNT_W-1:0] WAIT_LOAD = MR_CNT_W'(WAIT_STATES);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  mr_state_e            state_q, state_d;
  logic [MR_CNT_W-1:0]  cnt_q, cnt_d;
  mr_req_t              req_q, req_d;
  logic [31:0]          data_q, data_d;     // last completed read value
  logic                 err_q, err_d;       // range error of the current op
  logic                 rd_ram_q, rd_ram_d; // response comes from the RAM
  logic [31:0]          aux_q, aux_d;       // non-RAM read value (0 or I/O)

  // ---------------------------------------------------------------------------
  // Decode of the latched request
  // ---------------------------------------------------------------------------
  logic        req_seen;
  logic        req_accept;
  logic        access_fire;
  logic        rd_op;
  logic        both_op;
  logic        addr_in_ram;
  logic        io_hit;
  logic        ram_we;
  logic [31:0] ram_q;
  logic [31:0] resp_data;

  assign req_seen    = iRead | iWrite;
  assign req_accept  = (state_q == MR_IDLE) && req_seen;
  assign access_fire = (state_q == MR_ACCESS) && (cnt_q == '0);
  // A simultaneous read+write is treated as a write only.
  assign rd_op       = req_q.rd & ~req_q.wr;
  assign both_op     = req_q.rd &  req_q.wr;
  assign addr_in_ram = mr_in_ram(req_q.addr, ADDR_W, DEPTH);

  // The write is qualified with nRst so that a reset landing on the final
  // ACCESS cycle abandons the op instead of committing it to the RAM.
  assign ram_we = access_fire & req_q.wr & addr_in_ram & nRst;

`ifdef MEMRESP_IO_EN
  logic        io_in_hit;
  logic        io_out_hit;
  logic [31:0] out_port_q, out_port_d;

  assign io_in_hit  = (req_q.addr == MR_IO_IN_ADDR);
  assign io_out_hit = (req_q.addr == MR_IO_OUT_ADDR);
  assign io_hit     = io_in_hit | io_out_hit;
  assign oOutPort   = out_port_q;

  always_comb begin
    out_port_d = out_port_q;
    if (access_fire && req_q.wr && io_out_hit) begin
      out_port_d = req_q.data;
    end
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      out_port_q <= '0;
    end else begin
      out_port_q <= out_port_d;
    end
  end
`else
  assign io_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  mem_ram_sp #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .iClk  (iClk),
    .iWe   (ram_we),
    .iAddr (req_q.addr[ADDR_W-1:0]),
    .iD    (req_q.data),
    .oQ    (ram_q)
  );

  // RAM data arrives one cycle after the fire cycle, i.e. during DONE; every
  // other read source is captured at the fire cycle into aux_q.
  assign resp_data = rd_ram_q ? ram_q : aux_q;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state_q <= MR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MR_IDLE:   if (req_seen) state_d = MR_ACCESS;
      MR_ACCESS: if (cnt_q == '0) state_d = MR_DONE;
      // DONE always returns to IDLE; a request still held is re-accepted
      // there, one cycle later, never straight from DONE.
      MR_DONE:   state_d = MR_IDLE;
      default:   state_d = MR_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    oRdy  = 1'b0;
    oErr  = 1'b0;
    oData = data_q;
    unique case (state_q)
      MR_IDLE:   oRdy = ~req_seen;
      MR_ACCESS: oRdy = 1'b0;
      MR_DONE: begin
        oRdy = 1'b1;
        oErr = err_q;
        if (rd_op) begin
          oData = resp_data;
        end
      end
      default:   oRdy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    req_d    = req_q;
    data_d   = data_q;
    err_d    = err_q;
    rd_ram_d = rd_ram_q;
    aux_d    = aux_q;

    if (req_accept) begin
      // Latch the whole request; inputs are not looked at again until IDLE.
      req_d = '{rd: iRead, wr: iWrite, addr: iAddr, data: iData};
      cnt_d = WAIT_LOAD;
    end else if ((state_q == MR_ACCESS) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (access_fire) begin
      err_d    = ~addr_in_ram & ~io_hit & ~both_op;
      rd_ram_d = rd_op & addr_in_ram;
      aux_d    = '0;
`ifdef MEMRESP_IO_EN
      if (rd_op && io_in_hit) begin
        aux_d = iInPort;
      end else if (rd_op && io_out_hit) begin
        aux_d = out_port_q;
      end
`endif
    end

    if ((state_q == MR_DONE) && rd_op) begin
      data_d = resp_data;
    end
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      cnt_q    <= '0;
      req_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      rd_ram_q <= 1'b0;
      aux_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      data_q   <= data_d;
      err_q    <= err_d;
      rd_ram_q <= rd_ram_d;
      aux_q    <= aux_d;
    end
  end

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder (DEPTH=512, WAIT_STATES=1).
//   Stimulus is driven #1 after the rising edge, outputs sampled on the
//   falling edge. Expected values come from a word-level model: an
//   associative array of written words plus the last read value.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned WS     = 1;
  localparam int          LAT    = WS + 2;
  localparam int          BOUND  = 50;

  logic        iClk = 1'b0;
  logic        nRst;
  logic [31:0] iAddr;
  logic [31:0] iData;
  logic        iRead;
  logic        iWrite;
  logic [31:0] oData;
  logic        oRdy;
  logic        oErr;
`ifdef MEMRESP_IO_EN
  logic [31:0] iInPort;
  logic [31:0] oOutPort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] model_mem [int];
  logic [31:0] model_last;
`ifdef MEMRESP_IO_EN
  logic [31:0] model_out;
`endif

  always #5 iClk = ~iClk;

  mem_responder #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .WAIT_STATES (WS)
  ) dut (
    .iClk     (iClk),
    .nRst     (nRst),
    .iAddr    (iAddr),
    .iData    (iData),
    .iRead    (iRead),
    .iWrite   (iWrite),
`ifdef MEMRESP_IO_EN
    .iInPort  (iInPort),
    .oOutPort (oOutPort),
`endif
    .oData    (oData),
    .oRdy     (oRdy),
    .oErr     (oErr)
  );

  // ---------------------------------------------------------------------------
  // Reference model: outcome of one request at word level.
  // ---------------------------------------------------------------------------
  task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] in_port,
                             output logic [31:0] exp_q, output logic exp_e);
    bit in_ram;
    bit is_io;
    in_ram = (a < DEPTH);
    is_io  = 1'b0;
`ifdef MEMRESP_IO_EN
    is_io  = (a == 32'hFFFF_FFF0) || (a == 32'hFFFF_FFF1);
`endif
    if (wr) begin
      if (in_ram) model_mem[a] = d;
`ifdef MEMRESP_IO_EN
      if (a == 32'hFFFF_FFF1) model_out = d;
`endif
      exp_e = !(in_ram || is_io) && !rd;
      exp_q = model_last;
    end else begin
      exp_q = 32'h0;
      if (in_ram && model_mem.exists(a)) exp_q = model_mem[a];
`ifdef MEMRESP_IO_EN
      if (a == 32'hFFFF_FFF0) exp_q = in_port;
      if (a == 32'hFFFF_FFF1) exp_q = model_out;
`endif
      exp_e      = !(in_ram || is_io);
      model_last = exp_q;
    end
    if (in_port == 32'h0) begin end // in_port only matters with I/O built in
  endtask

  // Drive one request and wait for its oRdy pulse. Returns oData/oErr sampled
  // in the DONE cycle. With hold=0 the request is dropped in that cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, input string tag,
                        output logic [31:0] q, output logic e);
    int edges;
    edges = 0;
    @(posedge iClk); #1;
    iRead = rd; iWrite = wr; iAddr = a; iData = d;
    @(negedge iClk);
    while (!oRdy && edges < BOUND) begin
      @(posedge iClk);
      edges++;
      @(negedge iClk);
    end
    n_checks++;
    if (edges != LAT) begin
      n_errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", tag, edges, LAT);
    end
    q = oData;
    e = oErr;
    if (!hold) begin
      iRead  = 1'b0;
      iWrite = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    nRst = 1'b0; iRead = 1'b0; iWrite = 1'b0; iAddr = '0; iData = '0;
`ifdef MEMRESP_IO_EN
    iInPort = '0;
    model_out = '0;
`endif
    repeat (3) @(posedge iClk);
    #1 nRst = 1'b1;
    model_last = 32'h0;
    @(negedge iClk);
    n_checks++;
    if ({oRdy, oErr, oData} !== {1'b1, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset: rdy=%b err=%b data=%h, expected rdy=1 err=0 data=0",
               oRdy, oErr, oData);
    end
  endtask

  task automatic test_basic_rw();
    logic [31:0] q, eq;
    logic e, ee;
    access(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, "wr5", q, e);
    model_apply(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL wr5: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
    access(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, "rd5", q, e);
    model_apply(1'b1, 1'b0, 32'd5, 32'h0, 32'h0, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL rd5: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] q, eq;
    logic e, ee;
    bit rd_l [8]; bit wr_l [8]; logic [31:0] a_l [8]; logic [31:0] d_l [8];
    rd_l = '{0, 1, 0, 1, 1, 0, 1, 1};
    wr_l = '{1, 0, 1, 0, 0, 1, 0, 0};
    a_l  = '{32'd88, 32'd600, 32'd600, 32'd88, 32'h8000_0058,
             32'd511, 32'd511, 32'd512};
    d_l  = '{32'h8888_0088, 0, 32'h0BAD_0BAD, 0, 0, 32'h1234_5511, 0, 0};
    for (int i = 0; i < 8; i++) begin
      access(rd_l[i], wr_l[i], a_l[i], d_l[i], 1'b0, "oor", q, e);
      model_apply(rd_l[i], wr_l[i], a_l[i], d_l[i], 32'h0, eq, ee);
      n_checks++;
      if ({q, e} !== {eq, ee}) begin
        n_errors++;
        $display("FAIL oor[%0d] addr=%h: data=%h err=%b, expected data=%h err=%b",
                 i, a_l[i], q, e, eq, ee);
      end
    end
`ifndef MEMRESP_IO_EN
    access(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, "io_absent", q, e);
    model_apply(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL io_absent: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
`endif
  endtask

  task automatic test_rd_wr_both();
    logic [31:0] q, eq;
    logic e, ee;
    access(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, "pre_rd5", q, e);
    model_apply(1'b1, 1'b0, 32'd5, 32'h0, 32'h0, eq, ee);
    access(1'b1, 1'b1, 32'd7, 32'h12, 1'b0, "both7", q, e);
    model_apply(1'b1, 1'b1, 32'd7, 32'h12, 32'h0, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL both7: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
    access(1'b1, 1'b0, 32'd7, 32'h0, 1'b0, "rd7", q, e);
    model_apply(1'b1, 1'b0, 32'd7, 32'h0, 32'h0, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL rd7: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] q, eq;
    logic e, ee;
    access(1'b0, 1'b1, 32'd3, 32'h0000_0033, 1'b0, "wr3", q, e);
    model_apply(1'b0, 1'b1, 32'd3, 32'h0000_0033, 32'h0, eq, ee);
    @(posedge iClk); #1;
    iWrite = 1'b1; iAddr = 32'd3; iData = 32'h55;
    repeat (WS + 1) @(posedge iClk);   // now in the last ACCESS cycle
    #1 nRst = 1'b0;
    iWrite = 1'b0;
    @(posedge iClk); #1 nRst = 1'b1;
    model_last = 32'h0;
    @(negedge iClk);
    n_checks++;
    if ({oRdy, oErr, oData} !== {1'b1, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL rst_mid idle: rdy=%b err=%b data=%h, expected rdy=1 err=0 data=0",
               oRdy, oErr, oData);
    end
    access(1'b1, 1'b0, 32'd3, 32'h0, 1'b0, "rd3", q, e);
    model_apply(1'b1, 1'b0, 32'd3, 32'h0, 32'h0, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL rst_mid rd3: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
  endtask

  task automatic test_drop_in_access();
    logic [31:0] eq;
    logic ee;
    int edges;
    edges = 0;
    @(posedge iClk); #1;
    iRead = 1'b1; iAddr = 32'd5;
    @(posedge iClk); #1;               // accepted; now in ACCESS
    edges = 1;
    iRead = 1'b0; iAddr = 32'd7;       // must not be re-sampled
    @(negedge iClk);
    while (!oRdy && edges < BOUND) begin
      @(posedge iClk);
      edges++;
      @(negedge iClk);
    end
    model_apply(1'b1, 1'b0, 32'd5, 32'h0, 32'h0, eq, ee);
    n_checks++;
    if (edges != LAT || {oData, oErr} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL drop: edges=%0d data=%h err=%b, expected edges=%0d data=%h err=%b",
               edges, oData, oErr, LAT, eq, ee);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, eq;
    logic e, ee;
    int edges;
    edges = 0;
    access(1'b1, 1'b0, 32'd7, 32'h0, 1'b1, "b2b_first", q, e);
    model_apply(1'b1, 1'b0, 32'd7, 32'h0, 32'h0, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL b2b_first: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
    iAddr = 32'd5;                     // request stays asserted
    @(posedge iClk);
    @(negedge iClk);
    n_checks++;
    if (oRdy !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_stall: rdy=%b, expected 0", oRdy);
    end
    while (!oRdy && edges < BOUND) begin
      @(posedge iClk);
      edges++;
      @(negedge iClk);
    end
    model_apply(1'b1, 1'b0, 32'd5, 32'h0, 32'h0, eq, ee);
    n_checks++;
    if (edges != LAT || {oData, oErr} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL b2b_second: edges=%0d data=%h err=%b, expected edges=%0d data=%h err=%b",
               edges, oData, oErr, LAT, eq, ee);
    end
    iRead = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] q, eq, a, d;
    logic e, ee;
    bit rd, wr;
    int kind;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      access(1'b0, 1'b1, 32'(i + 16), d, 1'b0, "fill", q, e);
      model_apply(1'b0, 1'b1, 32'(i + 16), d, 32'h0, eq, ee);
    end
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(16, 31));
      d    = $urandom;
      rd   = (kind < 4) || (kind == 8);
      wr   = (kind >= 4 && kind < 8) || (kind == 9);
      if (kind == 6 || kind == 8) a = ($urandom & 32'h7FFF_FFFF) | 32'h0000_0200;
      if (kind == 9) rd = 1'b1;
      access(rd, wr, a, d, 1'b0, "rand", q, e);
      model_apply(rd, wr, a, d, 32'h0, eq, ee);
      n_checks++;
      if ({q, e} !== {eq, ee}) begin
        n_errors++;
        $display("FAIL rand[%0d] rd=%b wr=%b addr=%h: data=%h err=%b, expected data=%h err=%b",
                 i, rd, wr, a, q, e, eq, ee);
      end
      @(negedge iClk);
      n_checks++;
      if ({oRdy, oErr, oData} !== {1'b1, 1'b0, model_last}) begin
        n_errors++;
        $display("FAIL rand_hold[%0d]: rdy=%b err=%b data=%h, expected rdy=1 err=0 data=%h",
                 i, oRdy, oErr, oData, model_last);
      end
    end
  endtask

`ifdef MEMRESP_IO_EN
  task automatic test_io();
    logic [31:0] q, eq;
    logic e, ee;
    access(1'b0, 1'b1, 32'hFFFF_FFF1, 32'hA5, 1'b0, "io_wr", q, e);
    model_apply(1'b0, 1'b1, 32'hFFFF_FFF1, 32'hA5, 32'h0, eq, ee);
    n_checks++;
    if ({oOutPort, e} !== {model_out, ee}) begin
      n_errors++;
      $display("FAIL io_wr: out=%h err=%b, expected out=%h err=%b", oOutPort, e, model_out, ee);
    end
    iInPort = 32'h77;
    access(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, "io_in", q, e);
    model_apply(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h77, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL io_in: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
    access(1'b1, 1'b0, 32'hFFFF_FFF1, 32'h0, 1'b0, "io_out_rd", q, e);
    model_apply(1'b1, 1'b0, 32'hFFFF_FFF1, 32'h0, 32'h77, eq, ee);
    n_checks++;
    if ({q, e} !== {eq, ee}) begin
      n_errors++;
      $display("FAIL io_out_rd: data=%h err=%b, expected data=%h err=%b", q, e, eq, ee);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_rw();
    test_out_of_range();
    test_rd_wr_both();
    test_reset_mid_access();
    test_drop_in_access();
    test_back_to_back();
    test_random();
`ifdef MEMRESP_IO_EN
    test_io();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_responder
